// File: rtl/stack_mem_responder.sv
// stack_mem_responder: data-memory responder for the stack CPU RAM port.
// Single-port synchronous word array with one-cycle, write-first CPU reads,
// a req/ack host port for debug/load access, sticky error flags and a
// saturating count of accepted CPU writes.
// Optional feature macro: STACK_MEM_ZERO_FILL_EN -- when defined, the array is
// zero-filled after every reset (busy high while filling).
module stack_mem_responder #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [15:0] ERR_RDATA = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        wren,
    input  logic [15:0] data,
    output logic [15:0] q,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [15:0] host_addr,
    input  logic [15:0] host_wdata,
    output logic        host_ack,
    output logic [15:0] host_rdata,
    output logic        busy,
    output logic [2:0]  err,
    input  logic        err_clr,
    output logic [15:0] wr_count
);

    localparam int unsigned     AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0]     DEPTH_W  = 17'(DEPTH);
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_READY = 2'd1,
        ST_HOST  = 2'd2
    } state_t;

`ifdef STACK_MEM_ZERO_FILL_EN
    localparam state_t RESET_STATE = ST_FILL;
`else
    localparam state_t RESET_STATE = ST_READY;
`endif

    // Storage and state
    logic [15:0]   mem_r [DEPTH];
    state_t        state_r;
    state_t        state_nxt_s;
    logic [AW-1:0] fill_cnt_r;
    logic [15:0]   addr_prev_r;
    logic          h_we_r;
    logic [15:0]   h_addr_r;
    logic [15:0]   h_wdata_r;
    logic [15:0]   q_r;
    logic          host_ack_r;
    logic [15:0]   host_rdata_r;
    logic [2:0]    err_r;
    logic [15:0]   wr_count_r;

    // Combinational decode
    logic          cpu_in_range_s;
    logic          host_in_range_s;
    logic [AW-1:0] cpu_idx_s;
    logic [AW-1:0] host_idx_s;
    logic [AW-1:0] port_addr_s;
    logic          port_we_s;
    logic          mem_we_s;
    logic [15:0]   port_wdata_s;
    logic [15:0]   port_rdata_s;
    logic          host_accept_s;
    logic          collision_s;
    logic [2:0]    err_set_s;

    // Range check uses all 16 address bits; only the low bits index the array.
    assign cpu_in_range_s  = ({1'b0, address} < DEPTH_W);
    assign host_in_range_s = ({1'b0, h_addr_r} < DEPTH_W);
    assign cpu_idx_s       = address[AW-1:0];
    assign host_idx_s      = h_addr_r[AW-1:0];
    assign port_rdata_s    = mem_r[port_addr_s];
    // No array writes while reset is held, so a reset never corrupts contents.
    assign mem_we_s        = port_we_s & ~reset;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= RESET_STATE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, array port ownership and error events
    always_comb begin
        state_nxt_s   = state_r;
        port_addr_s   = cpu_idx_s;
        port_we_s     = 1'b0;
        port_wdata_s  = data;
        host_accept_s = 1'b0;
        collision_s   = 1'b0;
        err_set_s     = 3'b000;
        case (state_r)
            ST_FILL: begin
                port_addr_s  = fill_cnt_r;
                port_we_s    = 1'b1;
                port_wdata_s = 16'h0000;
                if (fill_cnt_r == LAST_IDX) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_READY: begin
                port_we_s    = wren & cpu_in_range_s;
                err_set_s[0] = ~cpu_in_range_s;
                if (host_req && !host_ack_r) begin
                    host_accept_s = 1'b1;
                    state_nxt_s   = ST_HOST;
                end else begin
                    state_nxt_s   = ST_READY;
                end
            end
            ST_HOST: begin
                // Host owns the port; any CPU activity this cycle is a collision.
                port_addr_s  = host_idx_s;
                port_we_s    = h_we_r & host_in_range_s;
                port_wdata_s = h_wdata_r;
                collision_s  = wren | (address != addr_prev_r);
                err_set_s[1] = ~host_in_range_s;
                err_set_s[2] = collision_s;
                state_nxt_s  = ST_READY;
            end
            default: begin
                state_nxt_s = RESET_STATE;
            end
        endcase
    end

    // Single-port array write
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem_r[port_addr_s] <= port_wdata_s;
        end
    end

    // Registered outputs, host request latch, fill counter and CPU address history
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fill_cnt_r   <= '0;
            addr_prev_r  <= 16'h0000;
            h_we_r       <= 1'b0;
            h_addr_r     <= 16'h0000;
            h_wdata_r    <= 16'h0000;
            q_r          <= 16'h0000;
            host_ack_r   <= 1'b0;
            host_rdata_r <= 16'h0000;
            err_r        <= 3'b000;
            wr_count_r   <= 16'h0000;
        end else begin
            addr_prev_r <= address;
            host_ack_r  <= (state_r == ST_HOST);
            // An error event in the same cycle as err_clr keeps its bit set.
            err_r       <= (err_clr ? 3'b000 : err_r) | err_set_s;
            case (state_r)
                ST_FILL: begin
                    fill_cnt_r <= fill_cnt_r + AW'(1);
                end
                ST_READY: begin
                    if (!cpu_in_range_s) begin
                        q_r <= ERR_RDATA;
                    end else if (wren) begin
                        q_r <= data;
                    end else begin
                        q_r <= port_rdata_s;
                    end
                    if (wren && cpu_in_range_s && (wr_count_r != 16'hFFFF)) begin
                        wr_count_r <= wr_count_r + 16'd1;
                    end
                    if (host_accept_s) begin
                        h_we_r    <= host_we;
                        h_addr_r  <= host_addr;
                        h_wdata_r <= host_wdata;
                    end
                end
                ST_HOST: begin
                    if (h_we_r) begin
                        host_rdata_r <= h_wdata_r;
                    end else if (host_in_range_s) begin
                        host_rdata_r <= port_rdata_s;
                    end else begin
                        host_rdata_r <= ERR_RDATA;
                    end
                end
                default: begin
                    fill_cnt_r <= '0;
                end
            endcase
        end
    end

`ifdef STACK_MEM_ZERO_FILL_EN
    logic busy_r;

    // busy tracks whether the next cycle is still part of the zero-fill
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b1;
        end else begin
            busy_r <= (state_nxt_s == ST_FILL);
        end
    end

    assign busy = busy_r;
`else
    assign busy = 1'b0;
`endif

    assign q          = q_r;
    assign host_ack   = host_ack_r;
    assign host_rdata = host_rdata_r;
    assign err        = err_r;
    assign wr_count   = wr_count_r;

endmodule

// File: tb/tb_stack_mem_responder.sv
// Self-checking bench for stack_mem_responder (DEPTH=256, ERR_RDATA=16'hFFFF).
// A transaction-level model predicts every output each cycle; directed
// vectors add hand-computed literal expectations.
module tb_stack_mem_responder;

    localparam int DEPTH = 256;

    logic        clock;
    logic        reset;
    logic [15:0] address;
    logic        wren;
    logic [15:0] data;
    logic [15:0] q;
    logic        host_req;
    logic        host_we;
    logic [15:0] host_addr;
    logic [15:0] host_wdata;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        busy;
    logic [2:0]  err;
    logic        err_clr;
    logic [15:0] wr_count;

    int checks   = 0;
    int failures = 0;

    stack_mem_responder #(.DEPTH(256), .ERR_RDATA(16'hFFFF)) dut (
        .clock(clock), .reset(reset), .address(address), .wren(wren), .data(data),
        .q(q), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .busy(busy), .err(err), .err_clr(err_clr), .wr_count(wr_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [15:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    int          m_fill_left;
    bit          m_host_pend;
    logic        m_hwe;
    logic [15:0] m_haddr, m_hwdata, m_prev_addr;
    logic [15:0] exp_q, exp_rdata, exp_wc;
    bit          exp_q_ok, exp_rd_ok, exp_ack, exp_busy;
    logic [2:0]  exp_err;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
`ifdef STACK_MEM_ZERO_FILL_EN
            m_fill_left <= DEPTH;
            exp_busy    <= 1'b1;
`else
            m_fill_left <= 0;
            exp_busy    <= 1'b0;
`endif
            m_host_pend <= 1'b0;
            exp_q       <= 16'h0000;
            exp_q_ok    <= 1'b1;
            exp_ack     <= 1'b0;
            exp_rdata   <= 16'h0000;
            exp_rd_ok   <= 1'b1;
            exp_err     <= 3'b000;
            exp_wc      <= 16'h0000;
        end else begin
            m_prev_addr <= address;
            exp_ack     <= m_host_pend;
            if (m_fill_left > 0) begin
                m_mem[DEPTH - m_fill_left]   <= 16'h0000;
                m_known[DEPTH - m_fill_left] <= 1'b1;
                m_fill_left <= m_fill_left - 1;
                exp_busy    <= (m_fill_left > 1);
                exp_err     <= err_clr ? 3'b000 : exp_err;
            end else if (m_host_pend) begin
                m_host_pend <= 1'b0;
                exp_err <= (err_clr ? 3'b000 : exp_err) |
                           {(wren || (address != m_prev_addr)), (m_haddr >= DEPTH), 1'b0};
                if (m_hwe) begin
                    exp_rdata <= m_hwdata;
                    exp_rd_ok <= 1'b1;
                    if (m_haddr < DEPTH) begin
                        m_mem[m_haddr[7:0]]   <= m_hwdata;
                        m_known[m_haddr[7:0]] <= 1'b1;
                    end
                end else if (m_haddr < DEPTH) begin
                    exp_rdata <= m_mem[m_haddr[7:0]];
                    exp_rd_ok <= m_known[m_haddr[7:0]];
                end else begin
                    exp_rdata <= 16'hFFFF;
                    exp_rd_ok <= 1'b1;
                end
            end else begin
                exp_err <= (err_clr ? 3'b000 : exp_err) | {2'b00, (address >= DEPTH)};
                if (address >= DEPTH) begin
                    exp_q    <= 16'hFFFF;
                    exp_q_ok <= 1'b1;
                end else if (wren) begin
                    exp_q    <= data;
                    exp_q_ok <= 1'b1;
                    m_mem[address[7:0]]   <= data;
                    m_known[address[7:0]] <= 1'b1;
                    exp_wc <= (exp_wc == 16'hFFFF) ? exp_wc : exp_wc + 16'd1;
                end else begin
                    exp_q    <= m_mem[address[7:0]];
                    exp_q_ok <= m_known[address[7:0]];
                end
                if (host_req && !exp_ack) begin
                    m_host_pend <= 1'b1;
                    m_hwe       <= host_we;
                    m_haddr     <= host_addr;
                    m_hwdata    <= host_wdata;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clock) begin
        if (!reset) begin
            if (exp_q_ok)  chk("q", q, exp_q);
            if (exp_rd_ok) chk("host_rdata", host_rdata, exp_rdata);
            chk("host_ack", host_ack, exp_ack);
            chk("err", err, exp_err);
            chk("wr_count", wr_count, exp_wc);
            chk("busy", busy, exp_busy);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (host_ack !== 1'b1 && n < 20);
        chk("host_ack_seen", host_ack, 1'b1);
    endtask

    int n;

    initial begin
        reset = 1'b0; address = 16'h0000; wren = 1'b0; data = 16'h0000;
        host_req = 1'b0; host_we = 1'b0; host_addr = 16'h0000; host_wdata = 16'h0000;
        err_clr = 1'b0;
        #1 reset = 1'b1;
        #2;
        chk("rst_q", q, 16'h0000);
        chk("rst_ack", host_ack, 1'b0);
        chk("rst_rdata", host_rdata, 16'h0000);
        chk("rst_err", err, 3'b000);
        chk("rst_wc", wr_count, 16'h0000);
        tick(2);
        reset = 1'b0;

`ifdef STACK_MEM_ZERO_FILL_EN
        chk("rst_busy", busy, 1'b1);
        address = 16'h0003; wren = 1'b1; data = 16'hDEAD;
        tick(10);
        address = 16'h0100;
        tick(3);
        wren = 1'b0; address = 16'h0000;
        tick(37);
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0005;
        tick(50);
        chk("fill_busy_mid", busy, 1'b1);
        chk("fill_no_ack", host_ack, 1'b0);
        chk("fill_no_err", err, 3'b000);
        chk("fill_no_wc", wr_count, 16'h0000);
        #2 reset = 1'b1;
        #1;
        chk("midfill_rst_ack", host_ack, 1'b0);
        chk("midfill_rst_err", err, 3'b000);
        chk("midfill_rst_busy", busy, 1'b1);
        host_req = 1'b0;
        @(negedge clock) reset = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk("fill_len", n, 256);
        chk("fill_wc", wr_count, 16'h0000);
        address = 16'h00A5;
        tick(1);
        chk("fill_zero_a5", q, 16'h0000);
`else
        chk("rst_busy", busy, 1'b0);
`endif

        // CPU write then read back
        address = 16'h0003; wren = 1'b1; data = 16'h1234;
        tick(1);
        wren = 1'b0;
        tick(1);
        chk("rd3", q, 16'h1234);
        chk("wc1", wr_count, 16'h0001);

        // Same-cycle write/read is write-first
        address = 16'h0007; wren = 1'b1; data = 16'hBEEF;
        tick(1);
        chk("wf7", q, 16'hBEEF);
        wren = 1'b0;
        tick(1);
        chk("rd7", q, 16'hBEEF);
        chk("wc2", wr_count, 16'h0002);

        address = 16'h0000; wren = 1'b1; data = 16'h0A0A;
        tick(1);
        address = 16'h0009; data = 16'h1111;
        tick(1);
        wren = 1'b0;
        chk("wc4", wr_count, 16'h0004);

        // Out-of-range CPU write (low bits alias address 0)
        address = 16'h0100; wren = 1'b1; data = 16'h5555;
        tick(1);
        chk("oob_q", q, 16'hFFFF);
        chk("oob_err", err, 3'b001);
        chk("oob_wc", wr_count, 16'h0004);
        wren = 1'b0; address = 16'h0000;
        tick(1);
        chk("no_alias", q, 16'h0A0A);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("err_clr", err, 3'b000);
        address = 16'h0200; err_clr = 1'b1;
        tick(1);
        chk("err_wins", err, 3'b001);
        address = 16'h0000;
        tick(1);
        err_clr = 1'b0;
        chk("err_clr2", err, 3'b000);

        // Host write then host read
        address = 16'h0009;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0005; host_wdata = 16'h00C3;
        wait_ack(n);
        chk("hw_latency", n, 2);
        chk("hw_rdata", host_rdata, 16'h00C3);
        host_req = 1'b0;
        tick(1);
        host_req = 1'b1; host_we = 1'b0;
        wait_ack(n);
        chk("hr_rdata", host_rdata, 16'h00C3);
        chk("hr_err", err, 3'b000);
        host_req = 1'b0;
        tick(1);

        // CPU write during the HOST cycle is dropped
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0003;
        tick(1);
        wren = 1'b1; address = 16'h0009; data = 16'h7777;
        tick(1);
        chk("col_ack", host_ack, 1'b1);
        chk("col_rdata", host_rdata, 16'h1234);
        host_req = 1'b0; wren = 1'b0;
        tick(1);
        chk("col_dropped", q, 16'h1111);
        chk("col_err", err, 3'b100);
        chk("col_wc", wr_count, 16'h0004);

        // Host out-of-range read
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0300;
        wait_ack(n);
        chk("hoob_rdata", host_rdata, 16'hFFFF);
        chk("hoob_err", err, 3'b010);
        host_req = 1'b0;
        tick(1);

        // wr_count saturation
        err_clr = 1'b1; address = 16'h000A; wren = 1'b1; data = 16'h0042;
        tick(1);
        err_clr = 1'b0;
        tick(65540);
        wren = 1'b0;
        tick(1);
        chk("wc_sat", wr_count, 16'hFFFF);

        // Reset during an accepted host request
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h000B; host_wdata = 16'hABCD;
        tick(1);
        #2 reset = 1'b1;
        #1;
        chk("hrst_ack", host_ack, 1'b0);
        chk("hrst_err", err, 3'b000);
        chk("hrst_q", q, 16'h0000);
        chk("hrst_wc", wr_count, 16'h0000);
        host_req = 1'b0;
        @(negedge clock) reset = 1'b0;
        tick(3);
        chk("hrst_no_ack", host_ack, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
